// File: rtl/rx_hdr_extract.sv
// Ingress header extractor: captures dst/src MAC and EtherType, counts frame
// length, and issues one classified descriptor per frame through a one-deep holding register.
module rx_hdr_extract #(
  parameter int unsigned PORT_ID       = 0,
  parameter int unsigned PORT_W        = 2,
  parameter int unsigned LEN_W         = 11,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1522,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  input  logic                  rx_last_i,
  input  logic                  rx_error_i,
  output logic                  desc_valid_o,
  input  logic                  desc_ready_i,
  output logic [47:0]           desc_dst_mac_o,
  output logic [47:0]           desc_src_mac_o,
  output logic [15:0]           desc_ethertype_o,
  output logic [LEN_W-1:0]      desc_len_o,
  output logic [PORT_W-1:0]     desc_port_o,
  output logic [2:0]            desc_err_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {S_DST, S_SRC, S_TYPE, S_PAY} state_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

  state_t           state;
  logic [2:0]       idx;
  logic [LEN_W-1:0] cnt;
  logic [47:0]      dst_sh, src_sh;
  logic [15:0]      type_sh;

  logic [47:0]      dst_nx, src_nx;
  logic [15:0]      type_nx;
  logic [LEN_W-1:0] len_nx;
  logic             eof, accept;

  assign eof    = rx_valid_i && rx_last_i;
  assign accept = desc_valid_o && desc_ready_i;

  // Bytes land at their fixed position so that a truncated header leaves
  // the unreceived bytes at zero.
  always_comb begin
    dst_nx  = dst_sh;
    src_nx  = src_sh;
    type_nx = type_sh;
    for (int unsigned i = 0; i < 6; i++) begin
      if (state == S_DST && idx == 3'(i)) dst_nx[8*(5-i) +: 8] = rx_data_i;
      if (state == S_SRC && idx == 3'(i)) src_nx[8*(5-i) +: 8] = rx_data_i;
    end
    for (int unsigned i = 0; i < 2; i++) begin
      if (state == S_TYPE && idx == 3'(i)) type_nx[8*(1-i) +: 8] = rx_data_i;
    end
    len_nx = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      state   <= S_DST;
      idx     <= '0;
      cnt     <= '0;
      dst_sh  <= '0;
      src_sh  <= '0;
      type_sh <= '0;
    end else if (rx_valid_i) begin
      if (rx_last_i) begin
        state   <= S_DST;
        idx     <= '0;
        cnt     <= '0;
        dst_sh  <= '0;
        src_sh  <= '0;
        type_sh <= '0;
      end else begin
        cnt     <= len_nx;
        dst_sh  <= dst_nx;
        src_sh  <= src_nx;
        type_sh <= type_nx;
        unique case (state)
          S_DST: begin
            if (idx == 3'd5) begin
              state <= S_SRC;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
          S_SRC: begin
            if (idx == 3'd5) begin
              state <= S_TYPE;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
          S_TYPE: begin
            if (idx == 3'd1) begin
              state <= S_PAY;
              idx   <= '0;
            end else idx <= idx + 1'b1;
          end
          S_PAY: idx <= '0;
          default: state <= S_DST;
        endcase
      end
    end
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      desc_valid_o     <= 1'b0;
      desc_dst_mac_o   <= '0;
      desc_src_mac_o   <= '0;
      desc_ethertype_o <= '0;
      desc_len_o       <= '0;
      desc_port_o      <= '0;
      desc_err_o       <= '0;
      drop_cnt_o       <= '0;
    end else if (eof && (!desc_valid_o || desc_ready_i)) begin
      desc_valid_o     <= 1'b1;
      desc_dst_mac_o   <= dst_nx;
      desc_src_mac_o   <= src_nx;
      desc_ethertype_o <= type_nx;
      desc_len_o       <= len_nx;
      desc_port_o      <= PORT_W'(PORT_ID);
      desc_err_o       <= {(len_nx > MAX_LEN), (len_nx < MIN_LEN), rx_error_i};
    end else if (eof) begin
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end else if (accept) begin
      desc_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_hdr_extract.sv
// Directed self-checking bench for rx_hdr_extract: header capture, length
// classification, descriptor handshake, drop counting and async reset.
module tb_rx_hdr_extract;

  localparam int unsigned LEN_W = 11;

  logic        switch_clk = 1'b0;
  logic        switch_rst_n = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_last_i = 1'b0;
  logic        rx_error_i = 1'b0;
  logic        desc_valid_o;
  logic        desc_ready_i = 1'b1;
  logic [47:0] desc_dst_mac_o;
  logic [47:0] desc_src_mac_o;
  logic [15:0] desc_ethertype_o;
  logic [LEN_W-1:0] desc_len_o;
  logic [1:0]  desc_port_o;
  logic [2:0]  desc_err_o;
  logic [15:0] drop_cnt_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  rx_hdr_extract #(
    .PORT_ID(2), .PORT_W(2), .LEN_W(LEN_W),
    .MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1522), .DROP_CNT_W(16)
  ) dut (
    .switch_clk(switch_clk), .switch_rst_n(switch_rst_n),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i),
    .rx_error_i(rx_error_i), .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .desc_dst_mac_o(desc_dst_mac_o), .desc_src_mac_o(desc_src_mac_o),
    .desc_ethertype_o(desc_ethertype_o), .desc_len_o(desc_len_o),
    .desc_port_o(desc_port_o), .desc_err_o(desc_err_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 switch_clk = ~switch_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input string tag, input logic [47:0] dst, input logic [47:0] src,
                          input logic [15:0] ty, input int unsigned len, input logic [2:0] err);
    chk({tag, ".valid"}, 64'(desc_valid_o), 64'd1);
    chk({tag, ".dst"},   64'(desc_dst_mac_o), 64'(dst));
    chk({tag, ".src"},   64'(desc_src_mac_o), 64'(src));
    chk({tag, ".type"},  64'(desc_ethertype_o), 64'(ty));
    chk({tag, ".len"},   64'(desc_len_o), 64'(len));
    chk({tag, ".err"},   64'(desc_err_o), 64'(err));
    chk({tag, ".port"},  64'(desc_port_o), 64'd2);
  endtask

  // Sends nsend bytes of a len-byte frame starting #1 after a clock edge;
  // rx_last_i only appears if the frame is sent to completion.
  task automatic send(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] ty,
                      input int unsigned len, input logic err, input logic rdy_last,
                      input int unsigned nsend);
    for (int unsigned i = 0; i < nsend; i++) begin
      rx_valid_i = 1'b1;
      if (i < 6)       rx_data_i = dst[8*(5-i) +: 8];
      else if (i < 12) rx_data_i = src[8*(11-i) +: 8];
      else if (i < 14) rx_data_i = ty[8*(13-i) +: 8];
      else             rx_data_i = 8'(i);
      rx_last_i  = (i == len - 1);
      rx_error_i = err && (i == len - 1);
      if (rdy_last && i == len - 1) desc_ready_i = 1'b1;
      @(posedge switch_clk);
      #1;
    end
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    rx_error_i = 1'b0;
  endtask

  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_A = 48'h0011_2233_4455;
  localparam logic [47:0] DST_B = 48'h0200_0000_0001;
  localparam logic [47:0] SRC_B = 48'h6677_8899_AABB;

  initial begin
    repeat (3) @(posedge switch_clk);
    #1;
    chk("rst.valid", 64'(desc_valid_o), 64'd0);
    chk("rst.drop",  64'(drop_cnt_o), 64'd0);
    chk("rst.dst",   64'(desc_dst_mac_o), 64'd0);
    chk("rst.len",   64'(desc_len_o), 64'd0);
    switch_rst_n = 1'b1;
    @(posedge switch_clk);
    #1;

    send(BCAST, SRC_A, 16'h0800, 82, 1'b0, 1'b0, 82);
    chk_desc("good", BCAST, SRC_A, 16'h0800, 82, 3'b000);
    @(posedge switch_clk); #1;
    chk("good.fall", 64'(desc_valid_o), 64'd0);

    send(BCAST, SRC_A, 16'h0800, 38, 1'b0, 1'b0, 38);
    chk_desc("runt38", BCAST, SRC_A, 16'h0800, 38, 3'b010);
    @(posedge switch_clk); #1;

    send(BCAST, SRC_A, 16'h0800, 10, 1'b0, 1'b0, 10);
    chk_desc("runt10", BCAST, 48'h0011_2233_0000, 16'h0000, 10, 3'b010);
    @(posedge switch_clk); #1;

    send(DST_B, SRC_B, 16'h0806, 63, 1'b0, 1'b0, 63);
    chk_desc("len63", DST_B, SRC_B, 16'h0806, 63, 3'b010);
    send(DST_B, SRC_B, 16'h0806, 64, 1'b0, 1'b0, 64);
    chk_desc("len64", DST_B, SRC_B, 16'h0806, 64, 3'b000);
    send(BCAST, SRC_A, 16'h0800, 1522, 1'b0, 1'b0, 1522);
    chk_desc("len1522", BCAST, SRC_A, 16'h0800, 1522, 3'b000);
    send(BCAST, SRC_A, 16'h0800, 1523, 1'b0, 1'b0, 1523);
    chk_desc("len1523", BCAST, SRC_A, 16'h0800, 1523, 3'b100);
    send(BCAST, SRC_A, 16'h0800, 1530, 1'b0, 1'b0, 1530);
    chk_desc("giant", BCAST, SRC_A, 16'h0800, 1530, 3'b100);
    send(BCAST, SRC_A, 16'h0800, 2100, 1'b0, 1'b0, 2100);
    chk_desc("lensat", BCAST, SRC_A, 16'h0800, 2047, 3'b100);
    send(BCAST, SRC_A, 16'h0800, 82, 1'b1, 1'b0, 82);
    chk_desc("macerr", BCAST, SRC_A, 16'h0800, 82, 3'b001);
    @(posedge switch_clk); #1;
    chk("macerr.fall", 64'(desc_valid_o), 64'd0);

    desc_ready_i = 1'b0;
    send(BCAST, SRC_A, 16'h0800, 82, 1'b0, 1'b0, 82);
    send(DST_B, SRC_B, 16'h86DD, 82, 1'b0, 1'b0, 82);
    chk_desc("bp.held", BCAST, SRC_A, 16'h0800, 82, 3'b000);
    chk("bp.drop", 64'(drop_cnt_o), 64'd1);
    repeat (3) @(posedge switch_clk);
    #1;
    chk_desc("bp.stable", BCAST, SRC_A, 16'h0800, 82, 3'b000);
    desc_ready_i = 1'b1;
    @(posedge switch_clk); #1;
    chk("bp.fall", 64'(desc_valid_o), 64'd0);
    chk("bp.drop2", 64'(drop_cnt_o), 64'd1);

    desc_ready_i = 1'b0;
    send(BCAST, SRC_A, 16'h0800, 82, 1'b0, 1'b0, 82);
    send(DST_B, SRC_B, 16'h86DD, 70, 1'b0, 1'b1, 70);
    chk_desc("simul", DST_B, SRC_B, 16'h86DD, 70, 3'b000);
    chk("simul.drop", 64'(drop_cnt_o), 64'd1);
    @(posedge switch_clk); #1;
    chk("simul.fall", 64'(desc_valid_o), 64'd0);

    desc_ready_i = 1'b0;
    send(BCAST, SRC_A, 16'h0800, 82, 1'b0, 1'b0, 82);
    send(DST_B, SRC_B, 16'h86DD, 82, 1'b0, 1'b0, 20);
    #2 switch_rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(desc_valid_o), 64'd0);
    chk("arst.drop",  64'(drop_cnt_o), 64'd0);
    chk("arst.dst",   64'(desc_dst_mac_o), 64'd0);
    chk("arst.src",   64'(desc_src_mac_o), 64'd0);
    chk("arst.len",   64'(desc_len_o), 64'd0);
    chk("arst.err",   64'(desc_err_o), 64'd0);
    chk("arst.port",  64'(desc_port_o), 64'd0);
    @(posedge switch_clk); #1;
    switch_rst_n = 1'b1;
    desc_ready_i = 1'b1;
    @(posedge switch_clk); #1;
    send(48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'h88F7, 82, 1'b0, 1'b0, 82);
    chk_desc("post_rst", 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 16'h88F7, 82, 3'b000);
    chk("post_rst.drop", 64'(drop_cnt_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
